// File: rtl/signal_def_pkg.sv
//==============================================================================
// Module : signal_def (package)
// Brief  : Shared fetch-unit definitions: FSM encoding, reset PC, word width.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package signal_def;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_queue.sv
//==============================================================================
// Module : fetch_queue
// Brief  : Circular instruction queue of {pc, instr} pairs with occupancy count.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module fetch_queue
    import signal_def::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [31:0]        wr_pc,
    input  logic [INSTR_W-1:0] wr_instr,
    input  logic               rd_en,
    output logic               rd_valid,
    output logic [31:0]        rd_pc,
    output logic [INSTR_W-1:0] rd_instr,
    output logic [AW:0]        count
);

    logic [31:0]        pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [AW-1:0]      head;
    logic [AW-1:0]      tail;
    logic               rd_fire;

    assign rd_valid = (count != '0);
    assign rd_fire  = rd_en && rd_valid;
    // Outputs read as zero when empty so reset and flush present a clean bus.
    assign rd_pc    = rd_valid ? pc_mem[head]    : '0;
    assign rd_instr = rd_valid ? instr_mem[head] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en)   tail <= tail + AW'(1);
            if (rd_fire) head <= head + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[tail]    <= wr_pc;
            instr_mem[tail] <= wr_instr;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
//==============================================================================
// Module : instr_fetch_unit
// Brief  : Credit-based instruction fetcher with redirect flush and decode queue.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module instr_fetch_unit
    import signal_def::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
    input  logic               out_ready
);

    localparam int          CW         = $clog2(DEPTH) + 1;
    localparam logic [CW:0] FULL_LEVEL = (CW+1)'(DEPTH);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   redirect_base;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] discard;
    logic [CW-1:0] discard_nxt;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] occ_nxt;
    logic [CW:0]   used_nxt;
    logic          accept;
    logic          resp_hit;
    logic          enq;
    logic          deq;

    assign redirect_base = redirect_pc & 32'hFFFF_FFFC;
    assign imem_req      = !rst && (state == ST_FETCH);
    assign imem_addr     = fetch_pc;
    assign accept        = imem_req && imem_ready;
    assign resp_hit      = imem_rvalid && (outstanding != '0);
    // Responses in FLUSH or landing on a redirect belong to the abandoned path.
    assign enq           = resp_hit && (state != ST_FLUSH) && !redirect_valid;
    assign deq           = out_valid && out_ready;

    assign outstanding_nxt = outstanding + CW'(accept) - CW'(resp_hit);
    assign occ_nxt         = occupancy + CW'(enq) - CW'(deq);
    assign used_nxt        = {1'b0, occ_nxt} + {1'b0, outstanding_nxt};

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        if (redirect_valid) begin
            // Everything still in flight after this edge is stale.
            discard_nxt = outstanding_nxt;
            state_nxt   = (discard_nxt != '0) ? ST_FLUSH : ST_FETCH;
        end else begin
            case (state)
                ST_FLUSH: begin
                    discard_nxt = discard - CW'(resp_hit);
                    if (discard_nxt == '0) state_nxt = ST_FETCH;
                end
                default: state_nxt = (used_nxt >= FULL_LEVEL) ? ST_STALL : ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FETCH;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_nxt;
            discard     <= discard_nxt;
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
            end else begin
                if (accept) fetch_pc <= pc_next(fetch_pc);
                if (enq)    resp_pc  <= pc_next(resp_pc);
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .wr_en    (enq),
        .wr_pc    (resp_pc),
        .wr_instr (imem_rdata),
        .rd_en    (out_ready),
        .rd_valid (out_valid),
        .rd_pc    (out_pc),
        .rd_instr (out_instr),
        .count    (occupancy)
    );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
//==============================================================================
// Module : tb_instr_fetch_unit
// Brief  : Self-checking bench: memory model, program-order scoreboard, directed cases.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int lat = 1;
    int cyc = 0;
    bit inject_stray = 1'b0;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } req_t;
    req_t pend[$];

    instr_fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: in-order responses, fixed latency 'lat', reset together with the DUT.
    initial begin
        req_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
            end else begin
                if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
                if (imem_req && imem_ready) begin
                    r.due  = cyc + lat;
                    r.addr = imem_addr;
                    pend.push_back(r);
                end
            end
            @(posedge clk);
            #1;
            if (inject_stray) begin
                imem_rvalid  = 1'b1;
                imem_rdata   = 32'hBAD0_BAD0;
                inject_stray = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(pend[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
        end
    end

    // Program-order model: fetch addresses and delivered instructions follow
    // a linear PC stream that restarts at every redirect or reset.
    logic [31:0] m_fetch = RST_PC;
    logic [31:0] m_exp   = RST_PC;
    bit          post_rst = 1'b0;
    bit          post_redir = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_req_low", imem_req, 0);
            m_fetch  = RST_PC;
            m_exp    = RST_PC;
            post_rst = 1'b1;
            post_redir = 1'b0;
        end else begin
            if (post_rst) begin
                check("post_rst_valid", out_valid, 0);
                check("post_rst_pc", out_pc, 0);
                check("post_rst_instr", out_instr, 0);
                check("post_rst_req", imem_req, 1);
            end
            if (post_redir) check("post_redir_valid", out_valid, 0);
            if (imem_req && imem_ready) begin
                check("model_fetch_addr", imem_addr, m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
            if (out_valid) begin
                check("model_out_pc", out_pc, m_exp);
                check("model_out_instr", out_instr, instr_of(m_exp));
                if (out_ready) m_exp = m_exp + 32'd4;
            end
            post_rst   = 1'b0;
            post_redir = 1'b0;
            if (redirect_valid) begin
                m_fetch    = redirect_pc & 32'hFFFF_FFFC;
                m_exp      = redirect_pc & 32'hFFFF_FFFC;
                post_redir = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int bound, input string name);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, out_valid, 1);
    endtask

    initial begin
        int          n_acc;
        int          n;
        int          n_low;
        bit          seen;
        logic [31:0] first_addr;
        logic [31:0] got[4];

        // Latency 1, free-flowing decode.
        lat = 1; imem_ready = 1'b1; out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        check("t1_first_req", imem_req, 1);
        check("t1_first_addr", imem_addr, RST_PC);
        wait_valid(20, "t1_wait_valid");
        check("t1_pc0", out_pc, 32'h0000_3000);
        @(negedge clk);
        check("t1_valid1", out_valid, 1);
        check("t1_pc1", out_pc, 32'h0000_3004);
        @(negedge clk);
        check("t1_pc2", out_pc, 32'h0000_3008);

        // Decode blocked: fill to credit limit, then drain.
        tick();
        lat = 1; imem_ready = 1'b1; out_ready = 1'b0;
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (imem_req && imem_ready) n_acc++;
        end
        check("t2_accepts", n_acc, 4);
        check("t2_stall_req", imem_req, 0);
        check("t2_head_pc", out_pc, 32'h0000_3000);
        tick();
        out_ready = 1'b1;
        n = 0; seen = 1'b0; first_addr = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid && out_ready && n < 4) begin
                got[n] = out_pc;
                n++;
            end
            if (imem_req && imem_ready && !seen) begin
                seen = 1'b1;
                first_addr = imem_addr;
            end
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_order%0d", i), got[i], 32'h0000_3000 + 32'(4 * i));
        check("t2_resume_addr", first_addr, 32'h0000_3010);

        // Latency 3, redirect with two requests in flight.
        tick();
        lat = 3; imem_ready = 1'b1; out_ready = 1'b1;
        do_reset();
        tick();
        tick();
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_3400;
        tick();
        redirect_valid = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        check("t3_flush_req", imem_req, 0);
        n_low = 1;
        for (int i = 0; i < 20 && !imem_req; i++) begin
            @(negedge clk);
            if (!imem_req) n_low++;
        end
        check("t3_flush_cycles", n_low, 2);
        check("t3_restart_addr", imem_addr, 32'h0000_3400);
        wait_valid(20, "t3_wait_valid");
        check("t3_pc", out_pc, 32'h0000_3400);

        // Memory not ready; a stray response with nothing outstanding.
        tick();
        lat = 1; imem_ready = 1'b0; out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) inject_stray = 1'b1;
            check("t4_addr_hold", imem_addr, 32'h0000_3000);
            check("t4_no_valid", out_valid, 0);
        end
        tick();
        imem_ready = 1'b1;
        wait_valid(20, "t4_wait_valid");
        check("t4_pc", out_pc, 32'h0000_3000);

        // Redirect to the top of the address space; low bits ignored.
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got[n] = out_pc;
                n++;
            end
        end
        check("t5_count", n, 2);
        check("t5_pc0", got[0], 32'hFFFF_FFFC);
        check("t5_pc1", got[1], 32'h0000_0000);

        // Reset mid-operation with entries queued and requests in flight.
        tick();
        lat = 3; imem_ready = 1'b1; out_ready = 1'b0;
        do_reset();
        tick(); tick(); tick(); tick();
        @(negedge clk);
        check("t6_pre_valid", out_valid, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid", out_valid, 0);
        check("t6_req", imem_req, 1);
        check("t6_addr", imem_addr, 32'h0000_3000);
        wait_valid(20, "t6_wait_valid");
        check("t6_pc", out_pc, 32'h0000_3000);
        tick();
        out_ready = 1'b1;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
